xdma_axis_tx: RTL and testbench

XDMA_AXIS_TX -- requirements
Module: xdma_axis_tx

---
 rtl/xdma_axis_tx.sv | 119 +++++++++++
 tb/tb_xdma_axis_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdma_axis_tx.sv
// Difftest word stream to AXI-stream (card-to-host) with fixed-length packets.
// Buffers words in a small FIFO, pads the open packet with zero beats on flush.
module xdma_axis_tx #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PKT_BEATS = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_data,
    input  logic         flush,
    output logic         axi_tvalid,
    input  logic         axi_tready,
    output logic [511:0] axi_tdata,
    output logic         axi_tlast,
    output logic         core_clock_enable,
    output logic [31:0]  pkt_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = $clog2(PKT_BEATS);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
    localparam logic [BW-1:0] LastBeat = BW'(PKT_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StSend, StPad} state_e;

    state_e        state_q, state_d;
    logic [511:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic          started_q;
    logic          cce_q, cce_d;
    logic [31:0]   pkt_count_q;
    logic          fifo_empty, fifo_full, push, pop, xfer;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FullCnt);
        // started_q keeps in_ready low until the first edge after reset release
        in_ready   = started_q && !fifo_full && !flush_pend_q;
        push       = in_valid && in_ready;
        axi_tlast  = (beat_cnt_q == LastBeat);

        axi_tvalid = 1'b0;
        axi_tdata  = '0;
        unique case (state_q)
            StSend: begin
                axi_tvalid = !fifo_empty;
                axi_tdata  = mem_q[rd_ptr_q];
            end
            StPad: axi_tvalid = 1'b1;
            default: ;
        endcase

        xfer    = axi_tvalid && axi_tready;
        pop     = xfer && (state_q == StSend);
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        beat_cnt_d = beat_cnt_q;
        if (xfer) begin
            beat_cnt_d = axi_tlast ? '0 : beat_cnt_q + 1'b1;
        end

        // Pending until nothing buffered and no packet open after this edge
        flush_pend_d = (flush_pend_q || flush) && ((beat_cnt_d != '0) || (count_d != '0));
        cce_d        = ((FullCnt - count_d) >= (AW + 1)'(2)) && !flush_pend_d;

        state_d = state_q;
        unique case (state_q)
            StIdle: if (!fifo_empty) state_d = StSend;
            StSend: begin
                if (xfer && axi_tlast && (count_d == '0)) begin
                    state_d = StIdle;
                end else if (flush_pend_q && fifo_empty && (beat_cnt_q != '0)) begin
                    state_d = StPad;
                end
            end
            StPad: if (xfer && axi_tlast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            started_q    <= 1'b0;
            cce_q        <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            started_q    <= 1'b1;
            cce_q        <= cce_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (xfer && axi_tlast) pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign core_clock_enable = cce_q;
    assign pkt_count         = pkt_count_q;

endmodule

// File: tb/tb_xdma_axis_tx.sv
// Scoreboard bench for xdma_axis_tx: directed packet scenarios plus randomized traffic
// checked against a packet-segmentation reference model.
module tb_xdma_axis_tx;

    localparam int P = 4;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic         flush;
    logic         axi_tvalid;
    logic         axi_tready;
    logic [511:0] axi_tdata;
    logic         axi_tlast;
    logic         core_clock_enable;
    logic [31:0]  pkt_count;

    xdma_axis_tx #(
        .DEPTH     (4),
        .PKT_BEATS (P)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .flush             (flush),
        .axi_tvalid        (axi_tvalid),
        .axi_tready        (axi_tready),
        .axi_tdata         (axi_tdata),
        .axi_tlast         (axi_tlast),
        .core_clock_enable (core_clock_enable),
        .pkt_count         (pkt_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [512:0] exp_q[$];   // {last, data}
    int           pos      = 0;
    int           pkt_model = 0;
    logic         hold      = 1'b0;
    logic [511:0] hold_data;
    logic         hold_last;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] word(input int n);
        logic [511:0] w;
        w = '0;
        w[31:0] = n;
        w[511:480] = 32'hA5A5_0000 + n;
        return w;
    endfunction

    // Samples 1 time unit before each rising edge: what is seen here is what the edge uses
    always begin
        logic [512:0] e;
        @(negedge clock);
        #4;
        if (!reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("tvalid_held", axi_tvalid, 1);
                chk("tdata_stable", axi_tdata, hold_data);
                chk("tlast_stable", axi_tlast, hold_last);
            end
            chk("pkt_count", pkt_count, pkt_model);
            if (axi_tvalid && axi_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {axi_tlast, axi_tdata}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {axi_tlast, axi_tdata}, e);
                    if (e[512]) pkt_model++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({pos == P - 1, in_data});
                pos = (pos + 1) % P;
            end
            if (flush) begin
                while (pos != 0) begin
                    exp_q.push_back({pos == P - 1, 512'd0});
                    pos = (pos + 1) % P;
                end
            end
            hold      = axi_tvalid && !axi_tready;
            hold_data = axi_tdata;
            hold_last = axi_tlast;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_word(input logic [511:0] d, input logic f);
        int   guard;
        logic acc;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = f;
        do begin
            #4;
            acc = in_ready;
            @(negedge clock);
            guard++;
        end while (!acc && guard < 200);
        in_valid = 1'b0;
        flush    = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || axi_tvalid) && g < 400) begin
            @(negedge clock);
            g++;
        end
        chk(name, exp_q.size(), 0);
        idle(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        axi_tready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cce", core_clock_enable, 0);
        chk("rst_tvalid", axi_tvalid, 0);
        chk("rst_tlast", axi_tlast, 0);
        chk("rst_tdata", axi_tdata, 0);
        chk("rst_pkt_count", pkt_count, 0);
        idle(2);
        reset = 1'b1;
        #1;
        chk("pre_edge_in_ready", in_ready, 0);
        idle(1);
        chk("post_rst_cce", core_clock_enable, 1);
        chk("post_rst_in_ready", in_ready, 1);

        // Eight words stream out as two packets
        base = pkt_model;
        axi_tready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(word(i), 1'b0);
        drain("req030_drain");
        chk("req030_pkts", pkt_count, base + 2);

        // Backpressure fills the FIFO
        base = pkt_model;
        axi_tready = 1'b0;
        push_word(word(11), 1'b0);
        push_word(word(12), 1'b0);
        chk("req031_cce_after2", core_clock_enable, 1);
        push_word(word(13), 1'b0);
        chk("req031_cce_after3", core_clock_enable, 0);
        chk("req031_in_ready_after3", in_ready, 1);
        push_word(word(14), 1'b0);
        chk("req031_in_ready_full", in_ready, 0);
        chk("req031_tvalid", axi_tvalid, 1);
        chk("req031_tdata_head", axi_tdata, word(11));
        idle(3);
        chk("req031_tdata_held", axi_tdata, word(11));
        axi_tready = 1'b1;
        drain("req031_drain");
        chk("req031_pkts", pkt_count, base + 1);
        chk("req031_cce_recovered", core_clock_enable, 1);

        // Partial packet closed by flush
        base = pkt_model;
        push_word(word(21), 1'b0);
        push_word(word(22), 1'b0);
        pulse_flush();
        chk("req032_in_ready_pend", in_ready, 0);
        chk("req032_cce_pend", core_clock_enable, 0);
        drain("req032_drain");
        chk("req032_pkts", pkt_count, base + 1);
        chk("req032_in_ready_after", in_ready, 1);

        // Flush with nothing open is ignored
        base = pkt_model;
        pulse_flush();
        chk("req033_in_ready", in_ready, 1);
        idle(3);
        chk("req033_tvalid", axi_tvalid, 0);
        chk("req033_pkts", pkt_count, base);

        // Flush with the sixth word: first packet normal, second padded
        base = pkt_model;
        for (int i = 1; i <= 5; i++) push_word(word(30 + i), 1'b0);
        push_word(word(36), 1'b1);
        drain("req034_drain");
        chk("req034_pkts", pkt_count, base + 2);

        // Reset in the middle of a packet
        axi_tready = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(word(40 + i), 1'b0);
        axi_tready = 1'b1;
        idle(2);
        reset = 1'b0;
        exp_q.delete();
        pos       = 0;
        pkt_model = 0;
        #1;
        chk("req035_tvalid", axi_tvalid, 0);
        chk("req035_tlast", axi_tlast, 0);
        chk("req035_tdata", axi_tdata, 0);
        chk("req035_in_ready", in_ready, 0);
        chk("req035_cce", core_clock_enable, 0);
        chk("req035_pkt_count", pkt_count, 0);
        idle(1);
        reset = 1'b1;
        idle(1);
        for (int i = 1; i <= 4; i++) push_word(word(50 + i), 1'b0);
        drain("req035_drain");
        chk("req035_pkts", pkt_count, 1);

        // Randomized traffic with backpressure and sporadic flushes
        for (int c = 0; c < 1500; c++) begin
            axi_tready = ($urandom_range(0, 3) != 0);
            in_valid   = ($urandom_range(0, 1) != 0);
            in_data    = {16{$urandom()}};
            flush      = ($urandom_range(0, 19) == 0);
            @(negedge clock);
        end
        in_valid   = 1'b0;
        axi_tready = 1'b1;
        pulse_flush();
        drain("random_drain");
        chk("random_pkts", pkt_count, pkt_model);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
